// File: rtl/cmp_serial_nbit_if.sv
// Handshake bundle for cmp_serial_nbit: operand/mode request and 1-bit result.
// in_signed exists only when CMP_SIGNED_EN is defined.
interface cmp_serial_nbit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       in_mode;
`ifdef CMP_SIGNED_EN
  logic             in_signed;
`endif
  logic             out_valid;
  logic             out_ready;
  logic             out_y;

  modport master (
    output in_valid, in_a, in_b, in_mode,
`ifdef CMP_SIGNED_EN
    output in_signed,
`endif
    output out_ready,
    input  in_ready, out_valid, out_y
  );

  modport slave (
    input  in_valid, in_a, in_b, in_mode,
`ifdef CMP_SIGNED_EN
    input  in_signed,
`endif
    input  out_ready,
    output in_ready, out_valid, out_y
  );
endinterface

// File: rtl/cmp_serial_nbit.sv
// Chunk-serial LT/LE/GT/GE comparator, CHUNK bits per cycle, LSB chunk first.
// Define CMP_SIGNED_EN to add the in_signed two's-complement option.
module cmp_serial_nbit #(
  parameter int WIDTH     = 32,
  parameter int CHUNK     = 4,
  parameter int IMPL_TYPE = 0
) (
  input logic            clk,
  input logic            rst,
  cmp_serial_nbit_if.slave bus
);
  localparam int NCHUNK = (CHUNK < 1) ? 1 : WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  if (CHUNK < 1) begin : g_bad_chunk
    $error("cmp_serial_nbit: CHUNK must be >= 1");
  end else if (WIDTH % CHUNK != 0) begin : g_bad_width
    $error("cmp_serial_nbit: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] yop;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic             ready_q;
  logic             valid_q;
  logic             y_q;

  logic [WIDTH-1:0] xa;
  logic [WIDTH-1:0] ya;
  logic [CHUNK:0]   bc;

  // GT/GE swap operands so every mode reduces to a borrow of X - Yop - mode[0].
  always_comb begin
    if (bus.in_mode[1]) begin
      xa = bus.in_b;
      ya = bus.in_a;
    end else begin
      xa = bus.in_a;
      ya = bus.in_b;
    end
`ifdef CMP_SIGNED_EN
    if (bus.in_signed) begin
      xa[WIDTH-1] = ~xa[WIDTH-1];
      ya[WIDTH-1] = ~ya[WIDTH-1];
    end
`endif
  end

  assign bc[0] = borrow;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    if (IMPL_TYPE == 0) begin : g_gate
      assign bc[i+1] = (~x[i] & yop[i])
                     | (~(x[i] ^ yop[i]) & bc[i]);
    end else begin : g_mux
      assign bc[i+1] = (x[i] == yop[i]) ? bc[i] : yop[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      x       <= '0;
      yop     <= '0;
      borrow  <= 1'b0;
      cnt     <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      y_q     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid && ready_q) begin
            x       <= xa;
            yop     <= ya;
            borrow  <= bus.in_mode[0];
            cnt     <= '0;
            ready_q <= 1'b0;
            state   <= RUN;
          end
        end
        RUN: begin
          x      <= x >> CHUNK;
          yop    <= yop >> CHUNK;
          borrow <= bc[CHUNK];
          if (cnt == LAST) begin
            cnt     <= '0;
            y_q     <= bc[CHUNK];
            valid_q <= 1'b1;
            state   <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = ready_q;
  assign bus.out_valid = valid_q;
  assign bus.out_y     = y_q;
endmodule

// File: tb/tb_cmp_serial_nbit.sv
// Directed bench for cmp_serial_nbit: CHUNK=2 main DUT plus CHUNK=8 and CHUNK=1.
// Expected results come from a signed/unsigned reference compare via a queue.
module tb_cmp_serial_nbit;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  logic exp_q[$];

  cmp_serial_nbit_if #(.WIDTH(8)) bus ();
  cmp_serial_nbit_if #(.WIDTH(8)) b8 ();
  cmp_serial_nbit_if #(.WIDTH(8)) b1 ();

  cmp_serial_nbit #(.WIDTH(8), .CHUNK(2), .IMPL_TYPE(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  cmp_serial_nbit #(.WIDTH(8), .CHUNK(8), .IMPL_TYPE(0)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (b8)
  );

  cmp_serial_nbit #(.WIDTH(8), .CHUNK(1), .IMPL_TYPE(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic model(input logic [7:0] a, input logic [7:0] b,
                                 input logic [1:0] m, input logic s);
    logic signed [8:0] ea;
    logic signed [8:0] eb;
    ea = s ? {a[7], a} : {1'b0, a};
    eb = s ? {b[7], b} : {1'b0, b};
    case (m)
      2'd0:    return ea < eb;
      2'd1:    return ea <= eb;
      2'd2:    return ea > eb;
      default: return ea >= eb;
    endcase
  endfunction

  task automatic txn(input logic [7:0] a, input logic [7:0] b,
                     input logic [1:0] m, input logic s, input int hold);
    int   lat;
    int   guard;
    logic y0;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_before", int'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_mode  = m;
`ifdef CMP_SIGNED_EN
    bus.in_signed = s;
`endif
    exp_q.push_back(model(a, b, m, s));
    bus.out_ready = (hold == 0);
    @(negedge clk);
    bus.in_a    = 8'($urandom);
    bus.in_b    = 8'($urandom);
    bus.in_mode = 2'($urandom_range(3));
`ifdef CMP_SIGNED_EN
    bus.in_signed = 1'($urandom_range(1));
`endif
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      chk("busy_ready", int'(bus.in_ready), 0);
      @(negedge clk);
      lat++;
    end
    bus.in_valid = 1'b0;
    chk("latency", lat, 4);
    y0 = bus.out_y;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", int'(bus.out_valid), 1);
      chk("hold_y", int'(bus.out_y), int'(y0));
      chk("hold_ready", int'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    chk("out_y", int'(bus.out_y), int'(exp_q.pop_front()));
    @(negedge clk);
    chk("handoff_valid", int'(bus.out_valid), 0);
    chk("handoff_ready", int'(bus.in_ready), 1);
  endtask

  task automatic aux(input logic [7:0] a, input logic [7:0] b,
                     input logic [1:0] m);
    int   lat8;
    int   lat1;
    logic y8;
    logic y1;
    lat8 = -1;
    lat1 = -1;
    y8   = 1'b0;
    y1   = 1'b0;
    b8.in_valid = 1'b1;
    b8.in_a     = a;
    b8.in_b     = b;
    b8.in_mode  = m;
    b1.in_valid = 1'b1;
    b1.in_a     = a;
    b1.in_b     = b;
    b1.in_mode  = m;
    exp_q.push_back(model(a, b, m, 1'b0));
    @(negedge clk);
    b8.in_valid = 1'b0;
    b1.in_valid = 1'b0;
    for (int t = 0; t < 30; t++) begin
      if (lat8 < 0 && b8.out_valid) begin
        lat8 = t;
        y8   = b8.out_y;
      end
      if (lat1 < 0 && b1.out_valid) begin
        lat1 = t;
        y1   = b1.out_y;
      end
      if (lat8 >= 0 && lat1 >= 0) break;
      @(negedge clk);
    end
    chk("lat_chunk8", lat8, 1);
    chk("lat_chunk1", lat1, 8);
    chk("y_chunk8", int'(y8), int'(exp_q[0]));
    chk("y_chunk1", int'(y1), int'(exp_q.pop_front()));
    @(negedge clk);
    chk("ready_chunk8", int'(b8.in_ready), 1);
    chk("ready_chunk1", int'(b1.in_ready), 1);
  endtask

  initial begin
    int seen;
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    bus.in_mode  = '0;
    bus.out_ready = 1'b1;
    b8.in_valid  = 1'b0;
    b8.in_a      = '0;
    b8.in_b      = '0;
    b8.in_mode   = '0;
    b8.out_ready = 1'b1;
    b1.in_valid  = 1'b0;
    b1.in_a      = '0;
    b1.in_b      = '0;
    b1.in_mode   = '0;
    b1.out_ready = 1'b1;
`ifdef CMP_SIGNED_EN
    bus.in_signed = 1'b0;
    b8.in_signed  = 1'b0;
    b1.in_signed  = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_ready", int'(bus.in_ready), 1);
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_y", int'(bus.out_y), 0);
    chk("rst_ready8", int'(b8.in_ready), 1);
    chk("rst_ready1", int'(b1.in_ready), 1);
    rst = 1'b0;
    @(negedge clk);

    txn(8'h03, 8'h05, 2'd0, 1'b0, 0);

    for (int m = 0; m < 4; m++)
      txn(8'hA7, 8'hA7, 2'(m), 1'b0, 0);

    txn(8'hFF, 8'h00, 2'd2, 1'b0, 5);

    bus.in_valid = 1'b1;
    bus.in_a     = 8'h00;
    bus.in_b     = 8'h01;
    bus.in_mode  = 2'd0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrun_rst_ready", int'(bus.in_ready), 1);
    chk("midrun_rst_valid", int'(bus.out_valid), 0);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    chk("midrun_no_result", seen, 0);

    txn(8'h00, 8'hFF, 2'd0, 1'b0, 0);
    txn(8'hFF, 8'hFF, 2'd3, 1'b0, 0);
    txn(8'h00, 8'h00, 2'd1, 1'b0, 0);
    txn(8'hFF, 8'h00, 2'd0, 1'b0, 1);
    txn(8'h00, 8'hFF, 2'd2, 1'b0, 0);

    for (int k = 0; k < 12; k++)
      txn(8'($urandom), 8'($urandom), 2'($urandom_range(3)), 1'b0,
          $urandom_range(2));

`ifdef CMP_SIGNED_EN
    txn(8'h80, 8'h01, 2'd0, 1'b1, 0);
    txn(8'h80, 8'h01, 2'd0, 1'b0, 0);
    txn(8'h7F, 8'h80, 2'd2, 1'b1, 0);
    txn(8'hFF, 8'hFF, 2'd1, 1'b1, 0);
    for (int k = 0; k < 6; k++)
      txn(8'($urandom), 8'($urandom), 2'($urandom_range(3)), 1'b1, 0);
`endif

    aux(8'h10, 8'h0F, 2'd3);
    aux(8'h03, 8'h05, 2'd0);
    aux(8'hA7, 8'hA7, 2'd2);
    aux(8'h00, 8'hFF, 2'd1);

    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
